// File: rtl/field_check_seq.sv
// field_check_seq: sequential collision checker for the tetris field.
// Scans the (rotated) piece mask one cell per clock against the occupancy
// field. It reports pass/fail, the failure reason and the first failing cell.

module field_check_seq #(
  parameter int FIELD_W = 20,
  parameter int FIELD_H = 20,
  parameter int BLK_N   = 4,
  parameter int POS_W   = 5
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic                                  pre_ok,
  input  logic [BLK_N*BLK_N-1:0]                block,
  input  logic [FIELD_W*FIELD_H-1:0]            field,
  input  logic [POS_W-1:0]                      block_pos_x,
  input  logic [POS_W-1:0]                      block_pos_y,
  input  logic [2:0]                            rotate,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  ok,
  output logic [1:0]                            fail_code,
  output logic [$clog2(BLK_N*BLK_N)-1:0]        hit_cell
);

  localparam int CELLS  = BLK_N * BLK_N;
  localparam int IDX_W  = $clog2(CELLS);
  localparam int CW     = POS_W + 2;
  localparam int FIDX_W = $clog2(FIELD_W * FIELD_H);

  localparam logic [1:0] CODE_NONE    = 2'd0;
  localparam logic [1:0] CODE_OVERLAP = 2'd1;
  localparam logic [1:0] CODE_BOUNDS  = 2'd2;
  localparam logic [1:0] CODE_PRE     = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic [CELLS-1:0]     block_q, block_d;
  logic [POS_W-1:0]     pos_x_q, pos_x_d;
  logic [POS_W-1:0]     pos_y_q, pos_y_d;
  logic [1:0]           rot_q, rot_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ok_q, ok_d;
  logic [1:0]           fail_code_q, fail_code_d;
  logic [IDX_W-1:0]     hit_cell_q, hit_cell_d;

  int                   bx;
  int                   by;
  int                   mi;
  logic                 cell_filled;
  logic [CW-1:0]        fx;
  logic [CW-1:0]        fy;
  logic                 in_bounds;
  logic [FIDX_W-1:0]    fidx;
  logic                 occupied;
  logic                 cell_fail;
  logic [1:0]           cell_code;

  // Test the current scan cell: rotated mask lookup, bounds first, then overlap.
  always_comb begin
    bx = int'(cnt_q) % BLK_N;
    by = int'(cnt_q) / BLK_N;
    mi = 0;
    case (rot_q)
      2'd0:    mi = by * BLK_N + bx;
      2'd1:    mi = BLK_N * (BLK_N - 1) + by - bx * BLK_N;
      2'd2:    mi = BLK_N * BLK_N - 1 - by * BLK_N - bx;
      default: mi = (BLK_N - 1) - by + bx * BLK_N;
    endcase
    cell_filled = block_q[IDX_W'(mi)];
    fx          = CW'(pos_x_q) + CW'(bx);
    fy          = CW'(pos_y_q) + CW'(by);
    in_bounds   = (fx < CW'(FIELD_W)) && (fy < CW'(FIELD_H));
    fidx        = in_bounds ? FIDX_W'(int'(fy) * FIELD_W + int'(fx)) : '0;
    occupied    = in_bounds && field[fidx];
    cell_fail   = cell_filled && (!in_bounds || occupied);
    cell_code   = in_bounds ? CODE_OVERLAP : CODE_BOUNDS;
  end

  // Next-state, request latching and result updates for the scan FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    block_d     = block_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    rot_d       = rot_q;
    ok_d        = ok_q;
    fail_code_d = fail_code_q;
    hit_cell_d  = hit_cell_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          block_d = block;
          pos_x_d = block_pos_x;
          pos_y_d = block_pos_y;
          rot_d   = 2'(rotate % 3'd4);
          cnt_d   = '0;
          if (pre_ok) begin
            state_d     = S_SCAN;
            ok_d        = 1'b0;
            fail_code_d = CODE_NONE;
            hit_cell_d  = '0;
          end else begin
            state_d     = S_DONE;
            ok_d        = 1'b0;
            fail_code_d = CODE_PRE;
            hit_cell_d  = '0;
          end
        end
      end
      S_SCAN: begin
        if (cell_fail) begin
          state_d     = S_DONE;
          ok_d        = 1'b0;
          fail_code_d = cell_code;
          hit_cell_d  = cnt_q;
        end else if (cnt_q == IDX_W'(CELLS - 1)) begin
          state_d     = S_DONE;
          ok_d        = 1'b1;
          fail_code_d = CODE_NONE;
          hit_cell_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State, latched request and registered outputs; reset aborts any scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      block_q     <= '0;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      rot_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
      fail_code_q <= '0;
      hit_cell_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      block_q     <= block_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      rot_q       <= rot_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ok_q        <= ok_d;
      fail_code_q <= fail_code_d;
      hit_cell_q  <= hit_cell_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ok        = ok_q;
  assign fail_code = fail_code_q;
  assign hit_cell  = hit_cell_q;

endmodule

// File: tb/tb_field_check_seq.sv
// tb_field_check_seq: scoreboard bench for field_check_seq with default parameters.

module tb_field_check_seq;

  localparam int FW = 20;
  localparam int FH = 20;
  localparam int NN = 4;
  localparam int PW = 5;

  logic           clk;
  logic           rst;
  logic           start;
  logic           pre_ok;
  logic [15:0]    block;
  logic [399:0]   field;
  logic [4:0]     block_pos_x;
  logic [4:0]     block_pos_y;
  logic [2:0]     rotate;
  logic           busy;
  logic           done;
  logic           ok;
  logic [1:0]     fail_code;
  logic [3:0]     hit_cell;

  int checks;
  int failures;

  typedef struct {
    logic       ok;
    logic [1:0] code;
    logic [3:0] hit;
    int         lat;
  } exp_t;

  typedef struct {
    logic       ok;
    logic [1:0] code;
    logic [3:0] hit;
    int         lat;
    logic       busy_bad;
    logic       busy_at_done;
    logic       busy_after;
    logic       done_after;
    logic       timeout;
  } obs_t;

  typedef struct {
    logic [15:0] blk;
    int          px;
    int          py;
    int          rot;
    int          fsel;
    logic        eok;
    logic [1:0]  ecode;
    logic [3:0]  ehit;
    int          elat;
  } tcase_t;

  exp_t sb_q[$];

  field_check_seq #(
    .FIELD_W(FW),
    .FIELD_H(FH),
    .BLK_N(NN),
    .POS_W(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .pre_ok(pre_ok),
    .block(block),
    .field(field),
    .block_pos_x(block_pos_x),
    .block_pos_y(block_pos_y),
    .rotate(rotate),
    .busy(busy),
    .done(done),
    .ok(ok),
    .fail_code(fail_code),
    .hit_cell(hit_cell)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish (got running, need finished)");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference behaviour written directly from the cell-by-cell description.
  function automatic exp_t model(input logic [15:0] blk, input logic [399:0] fld,
                                 input int px, input int py, input int rot, input logic pre);
    exp_t e;
    int r, bx, by, mi, fx, fy;
    e.ok = 1'b0; e.code = 2'd0; e.hit = 4'd0; e.lat = 0;
    if (!pre) begin
      e.code = 2'd3;
      e.lat  = 1;
      return e;
    end
    r = rot % 4;
    for (int k = 0; k < 16; k++) begin
      bx = k % 4;
      by = k / 4;
      case (r)
        0: mi = by * 4 + bx;
        1: mi = 12 + by - bx * 4;
        2: mi = 15 - by * 4 - bx;
        default: mi = 3 - by + bx * 4;
      endcase
      if (blk[mi]) begin
        fx = px + bx;
        fy = py + by;
        if (fx >= FW || fy >= FH) begin
          e.code = 2'd2; e.hit = 4'(k); e.lat = k + 2;
          return e;
        end
        if (fld[fy * FW + fx]) begin
          e.code = 2'd1; e.hit = 4'(k); e.lat = k + 2;
          return e;
        end
      end
    end
    e.ok  = 1'b1;
    e.lat = 17;
    return e;
  endfunction

  // Drive one request in cycle 0 and push its expected result.
  task automatic applyStimulus(input logic [15:0] blk, input int px, input int py,
                               input int rot, input logic pre, input exp_t e);
    block       = blk;
    block_pos_x = 5'(px);
    block_pos_y = 5'(py);
    rotate      = 3'(rot);
    pre_ok      = pre;
    start       = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    start       = 1'b0;
  endtask

  // Wait (bounded) for done from cycle 1, then look at the cycle after it.
  task automatic collect(output obs_t o);
    o.lat = 1; o.busy_bad = 1'b0; o.timeout = 1'b0;
    while (done !== 1'b1 && o.lat < 40) begin
      if (busy !== 1'b1) o.busy_bad = 1'b1;
      @(posedge clk); #1;
      o.lat++;
    end
    o.timeout      = (done !== 1'b1);
    o.ok           = ok;
    o.code         = fail_code;
    o.hit          = hit_cell;
    o.busy_at_done = busy;
    @(posedge clk); #1;
    o.busy_after   = busy;
    o.done_after   = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pre_ok = 1'b1; block = '0; field = '0;
    block_pos_x = '0; block_pos_y = '0; rotate = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, ok, fail_code, hit_cell} !== 9'd0) begin
      failures++;
      $display("[TB] FAIL reset_hold: got busy=%b done=%b ok=%b code=%0d hit=%0d, need all 0",
               busy, done, ok, fail_code, hit_cell);
    end
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checks++;
    if ({busy, done, ok, fail_code, hit_cell} !== 9'd0) begin
      failures++;
      $display("[TB] FAIL reset_idle: got busy=%b done=%b ok=%b code=%0d hit=%0d, need all 0",
               busy, done, ok, fail_code, hit_cell);
    end
  endtask

  task automatic test_table();
    tcase_t tc[9];
    exp_t   e;
    obs_t   o;
    tc[0] = '{16'h000F,  0,  0, 0, 0, 1'b1, 2'd0, 4'd0,  17};
    tc[1] = '{16'h000F,  0,  0, 0, 1, 1'b0, 2'd1, 4'd2,   4};
    tc[2] = '{16'h000F, 18,  0, 0, 0, 1'b0, 2'd2, 4'd2,   4};
    tc[3] = '{16'h000F, 17,  0, 1, 0, 1'b0, 2'd2, 4'd3,   5};
    tc[4] = '{16'h000F, 17,  0, 5, 0, 1'b0, 2'd2, 4'd3,   5};
    tc[5] = '{16'h8000, 16, 16, 0, 0, 1'b1, 2'd0, 4'd0,  17};
    tc[6] = '{16'h8000, 16, 17, 0, 0, 1'b0, 2'd2, 4'd15, 17};
    tc[7] = '{16'h0001, 16, 16, 2, 2, 1'b0, 2'd1, 4'd15, 17};
    tc[8] = '{16'h0001,  0, 17, 3, 0, 1'b0, 2'd2, 4'd12, 14};
    for (int i = 0; i < 9; i++) begin
      field = '0;
      if (tc[i].fsel == 1) field[2] = 1'b1;
      if (tc[i].fsel == 2) field[399] = 1'b1;
      e.ok = tc[i].eok; e.code = tc[i].ecode; e.hit = tc[i].ehit; e.lat = tc[i].elat;
      applyStimulus(tc[i].blk, tc[i].px, tc[i].py, tc[i].rot, 1'b1, e);
      collect(o);
      e = sb_q.pop_front();
      checks++;
      if (o.timeout || {o.ok, o.code, o.hit} !== {e.ok, e.code, e.hit} || o.lat != e.lat) begin
        failures++;
        $display("[TB] FAIL table%0d result: got ok=%b code=%0d hit=%0d lat=%0d timeout=%b, need ok=%b code=%0d hit=%0d lat=%0d",
                 i, o.ok, o.code, o.hit, o.lat, o.timeout, e.ok, e.code, e.hit, e.lat);
      end
      checks++;
      if ({o.busy_bad, o.busy_at_done, o.busy_after, o.done_after} !== 4'b0100) begin
        failures++;
        $display("[TB] FAIL table%0d busy: got gap=%b at_done=%b after=%b done_after=%b, need 0 1 0 0",
                 i, o.busy_bad, o.busy_at_done, o.busy_after, o.done_after);
      end
    end
  endtask

  task automatic test_pre_ok();
    field = '0; block = 16'h000F; block_pos_x = '0; block_pos_y = '0; rotate = '0;
    pre_ok = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({done, busy, ok, fail_code, hit_cell} !== {1'b1, 1'b1, 1'b0, 2'd3, 4'd0}) begin
      failures++;
      $display("[TB] FAIL pre_ok_done: got done=%b busy=%b ok=%b code=%0d hit=%0d, need 1 1 0 3 0",
               done, busy, ok, fail_code, hit_cell);
    end
    pre_ok = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL pre_ok_ignore_c2: got busy=%b done=%b, need 0 0", busy, done);
    end
    @(posedge clk); #1;
    checks++;
    if ({busy, done, fail_code} !== {1'b0, 1'b0, 2'd3}) begin
      failures++;
      $display("[TB] FAIL pre_ok_ignore_c3: got busy=%b done=%b code=%0d, need 0 0 3",
               busy, done, fail_code);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    obs_t o;
    int   stray;
    field = '0; block = 16'h000F; block_pos_x = '0; block_pos_y = '0; rotate = '0;
    pre_ok = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, ok, fail_code, hit_cell} !== 9'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_outputs: got busy=%b done=%b ok=%b code=%0d hit=%0d, need all 0",
               busy, done, ok, fail_code, hit_cell);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    stray = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("[TB] FAIL reset_mid_no_done: got %0d active cycles, need 0", stray);
    end
    e = model(16'h000F, field, 0, 0, 0, 1'b1);
    applyStimulus(16'h000F, 0, 0, 0, 1'b1, e);
    collect(o);
    e = sb_q.pop_front();
    checks++;
    if (o.timeout || {o.ok, o.code, o.hit} !== {e.ok, e.code, e.hit} || o.lat != e.lat) begin
      failures++;
      $display("[TB] FAIL reset_mid_rerun: got ok=%b code=%0d hit=%0d lat=%0d, need ok=%b code=%0d hit=%0d lat=%0d",
               o.ok, o.code, o.hit, o.lat, e.ok, e.code, e.hit, e.lat);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    obs_t o;
    field = '0;
    field[5 * FW + 7] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = model(16'h0660, field, 5 + i, 3, i, 1'b1);
      applyStimulus(16'h0660, 5 + i, 3, i, 1'b1, e);
      collect(o);
      e = sb_q.pop_front();
      checks++;
      if (o.timeout || {o.ok, o.code, o.hit} !== {e.ok, e.code, e.hit} || o.lat != e.lat) begin
        failures++;
        $display("[TB] FAIL b2b%0d result: got ok=%b code=%0d hit=%0d lat=%0d, need ok=%b code=%0d hit=%0d lat=%0d",
                 i, o.ok, o.code, o.hit, o.lat, e.ok, e.code, e.hit, e.lat);
      end
      checks++;
      if ({o.busy_bad, o.busy_at_done, o.busy_after, o.done_after} !== 4'b0100) begin
        failures++;
        $display("[TB] FAIL b2b%0d busy: got gap=%b at_done=%b after=%b done_after=%b, need 0 1 0 0",
                 i, o.busy_bad, o.busy_at_done, o.busy_after, o.done_after);
      end
    end
  endtask

  task automatic test_random();
    exp_t        e;
    obs_t        o;
    logic [15:0] blk;
    int          px, py, rot;
    logic        pre;
    for (int i = 0; i < 30; i++) begin
      for (int j = 0; j < 400; j++) field[j] = ($urandom_range(0, 11) == 0);
      blk = 16'($urandom & $urandom);
      px  = $urandom_range(0, 22);
      py  = $urandom_range(0, 22);
      rot = $urandom_range(0, 7);
      pre = ($urandom_range(0, 7) != 0);
      e = model(blk, field, px, py, rot, pre);
      applyStimulus(blk, px, py, rot, pre, e);
      collect(o);
      e = sb_q.pop_front();
      checks++;
      if (o.timeout || {o.ok, o.code, o.hit} !== {e.ok, e.code, e.hit} || o.lat != e.lat) begin
        failures++;
        $display("[TB] FAIL rand%0d result: blk=%h pos=(%0d,%0d) rot=%0d pre=%b got ok=%b code=%0d hit=%0d lat=%0d, need ok=%b code=%0d hit=%0d lat=%0d",
                 i, blk, px, py, rot, pre, o.ok, o.code, o.hit, o.lat, e.ok, e.code, e.hit, e.lat);
      end
      checks++;
      if ({o.busy_bad, o.busy_at_done, o.busy_after, o.done_after} !== 4'b0100) begin
        failures++;
        $display("[TB] FAIL rand%0d busy: got gap=%b at_done=%b after=%b done_after=%b, need 0 1 0 0",
                 i, o.busy_bad, o.busy_at_done, o.busy_after, o.done_after);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_table();
    test_pre_ok();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/field_check_seq.md
# field_check_seq

Multi-cycle, parametrised collision checker for the tetris game logic. On a `start` pulse it scans every cell of an N×N piece mask against the occupancy field, one cell per clock. The piece mask is rotated, and the field is W×H. The block reports whether the piece fits, and if it does not, the reason and the first offending cell. It sits between the piece/move controller, which requests trial moves and rotations, and the field register, which it reads only. It replaces the combinational field check with a bounded-fanout, timing-friendly scan.

## Interface
Parameters:
- `FIELD_W`, 20, field width in cells.
- `FIELD_H`, 20, field height in cells.
- `BLK_N`, 4, piece mask edge length (mask is BLK_N*BLK_N bits).
- `POS_W`, 5, width of piece position coordinates.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  request a check; sampled only in IDLE.
- `pre_ok`  in  1  result of the upstream block-shape check; 0 forces an immediate fail.
- `block`  in  BLK_N*BLK_N  piece mask, bit `by*BLK_N+bx`, 1 = filled.
- `field`  in  FIELD_W*FIELD_H  occupancy, bit `y*FIELD_W+x`, 1 = occupied.
- `block_pos_x`, `block_pos_y`  in  POS_W  field coordinates of mask cell (0,0).
- `rotate`  in  3  rotation count; only `rotate mod 4` is used.
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle.
- `done`  out  1  one-cycle pulse; result outputs are valid from this cycle.
- `ok`  out  1  1 = piece fits.
- `fail_code`  out  2  0 none, 1 overlap, 2 out of bounds, 3 `pre_ok` low.
- `hit_cell`  out  clog2(BLK_N*BLK_N)  scan index of the first failing cell; 0 when not applicable.

## Operation
- States:
  - IDLE: `start`=1 with `pre_ok`=1 goes to SCAN with cnt=0. `start`=1 with `pre_ok`=0 goes to DONE with fail_code=3.
  - SCAN: the current cell is tested each cycle; on a fail, or when cnt=BLK_N*BLK_N-1, go to DONE; otherwise increment cnt.
  - DONE: always returns to IDLE.
- On acceptance, `block`, `block_pos_x`, `block_pos_y` and `rotate mod 4` are latched. `field` is not latched; the requester must hold it stable while `busy`=1.
- Scan order: bx = cnt mod BLK_N, by = cnt / BLK_N.
- Mask index by rotation (N=BLK_N):
  - r0: by*N+bx
  - r1: N*(N-1)+by-bx*N
  - r2: N*N-1-by*N-bx
  - r3: (N-1)-by+bx*N
- Cells whose mask bit is 0 always pass.
- A filled cell at fx=pos_x+bx, fy=pos_y+by is tested in priority order:
  - Bounds first: fx>=FIELD_W or fy>=FIELD_H is fail_code=2.
  - Then overlap: field[fy*FIELD_W+fx]=1 is fail_code=1.
  - The field is never indexed for an out-of-bounds cell.
- Coordinate sums are computed at POS_W+2 bits, so no wrap-around can make an out-of-range cell appear in range.
- Result registers (`ok`, `fail_code`, `hit_cell`) update on entry to DONE and then hold until the next accepted `start`.
- A pass sets ok=1, fail_code=0, hit_cell=0.
- `start` while `busy`=1 is ignored; it is not queued.
- `rst` mid-scan returns the block to IDLE with all outputs 0. No `done` is produced for the aborted check.

## Timing
- Reset values: `busy`=0, `done`=0, `ok`=0, `fail_code`=0, `hit_cell`=0, state IDLE, cnt=0.
- Cycle numbering: `start` is high in cycle 0 and sampled at the end of cycle 0.
- The cell with cnt=k is tested in cycle k+1.
- `done` latency:
  - Fail at cell k: `done` in cycle k+2.
  - Full pass: `done` in cycle BLK_N*BLK_N+1, which is 17 for N=4.
  - `pre_ok`=0: `done` in cycle 1.
- `busy` is high from cycle 1 through the `done` cycle inclusive, and low the cycle after.
- A new `start` can be accepted in the first cycle `busy`=0, so the minimum start-to-start spacing is latency+1.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Empty field, block=16'h000F, pos (0,0), rot 0, pre_ok=1 -> `done` in cycle 17, ok=1, fail_code=0, `busy` high in cycles 1–17.
- Same request with field bit 2 set -> `done` in cycle 4, ok=0, fail_code=1, hit_cell=2.
- block=16'h000F, pos (18,0), rot 0 -> `done` in cycle 4, fail_code=2, hit_cell=2 (fx=20).
- block=16'h000F, pos (17,0), rot 1 -> the filled column is at bx=3, so `done` in cycle 5, fail_code=2, hit_cell=3. With rot 5 the response is identical.
- `start` with pre_ok=0 -> `done` in cycle 1, ok=0, fail_code=3. A second `start` pulsed in cycle 1 is ignored.
- Start a passing check, assert `rst` in cycle 6 -> all outputs 0 immediately. No `done` pulse follows. A new `start` after reset completes normally in 17 cycles.
